button_event_arbiter: RTL

Collects rising edges from `N_BTN` asynchronous-looking push-button/strobe inputs and queues one pending event per input. It serialises the events to a single consumer, such as the image-filter mode/command controller, over a valid/ready handshake. Simultaneous presses are granted round-robin. A programmable hold-off after each accepted event paces the consumer.

---
 rtl/button_evt_pkg.sv | 37 +++
 rtl/button_event_arbiter_if.sv | 14 +
 rtl/single_posedge_detector.sv | 23 ++
 rtl/button_event_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/button_evt_pkg.sv
// Shared types and the round-robin grant search for the button event arbiter.
// The search is combinational and sized for up to 16 requesters.
package button_evt_pkg;

  typedef enum logic [1:0] {IDLE, PRESENT, HOLD} evt_state_t;

  localparam int unsigned RR_MAX_N = 16;
  localparam int unsigned RR_IDX_W = 4;

  // First set bit of req[n-1:0] searching upward from last+1 with wrap; returns last if none.
  function automatic logic [RR_IDX_W-1:0] rr_next_grant(
    input logic [RR_MAX_N-1:0] req,
    input logic [RR_IDX_W-1:0] last,
    input int unsigned         n
  );
    logic [RR_IDX_W-1:0] pick;
    logic                hit;
    logic [RR_IDX_W:0]   sum;
    pick = last;
    hit  = 1'b0;
    for (int unsigned off = 1; off <= RR_MAX_N; off++) begin
      if (off <= n) begin
        // last < n and off <= n, so one subtraction is enough to wrap
        sum = {1'b0, last} + (RR_IDX_W+1)'(off);
        if (32'(sum) >= n) begin
          sum = sum - (RR_IDX_W+1)'(n);
        end
        if (!hit && req[sum[RR_IDX_W-1:0]]) begin
          pick = sum[RR_IDX_W-1:0];
          hit  = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event handshake between the arbiter (master) and its consumer (slave).
// evt_valid/evt_id stay stable until the consumer raises evt_ready.
interface button_event_arbiter_if #(
  parameter int N_BTN = 4
);
  localparam int ID_W = $clog2(N_BTN);

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/single_posedge_detector.sv
// Rising-edge detector: pulse is high for one cycle after level is first sampled high.
// Latency: pulse is combinational from two flops, one cycle after the sample; no backpressure.
module single_posedge_detector (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);
  logic cur_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= level;
      prev_q <= cur_q;
    end
  end

  assign pulse = cur_q & ~prev_q;
endmodule

// File: rtl/button_event_arbiter.sv
// Queues one event per button rising edge and serialises them round-robin to one consumer.
// Latency: evt_valid two cycles after first high sample; backpressure: holds event until evt_ready.
module button_event_arbiter
  import button_evt_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int HOLDOFF_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_BTN-1:0]              btn_in,
  button_event_arbiter_if.master        evt,
  output logic [N_BTN-1:0]              pending,
  output logic                          overrun
);
  localparam int ID_W  = $clog2(N_BTN);
  localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : CNT_W'(0);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_BTN - 1);

  evt_state_t        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   pick;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BTN-1:0]  btn_edge;
  logic [N_BTN-1:0]  pend_q, pend_d;
  logic [N_BTN-1:0]  grant_oh;
  logic              ovr_q, ovr_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_edge
    single_posedge_detector u_det (
      .clk   (clk),
      .reset (reset),
      .level (btn_in[i]),
      .pulse (btn_edge[i])
    );
  end

  assign pick = ID_W'(rr_next_grant(RR_MAX_N'(pend_q), RR_IDX_W'(last_q), N_BTN));

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    grant_oh = '0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          grant_oh = {{(N_BTN-1){1'b0}}, 1'b1} << pick;
          id_d     = pick;
          last_d   = pick;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (evt.evt_ready) begin
          if (HOLDOFF_CYCLES > 0) begin
            state_d = HOLD;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge on the input being granted re-queues it rather than overrunning
    pend_d = (pend_q & ~grant_oh) | btn_edge;
    ovr_d  = |(btn_edge & pend_q & ~grant_oh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign evt.evt_valid = (state_q == PRESENT);
  assign evt.evt_id    = id_q;
  assign pending       = pend_q;
  assign overrun       = ovr_q;
endmodule
